// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory port between I/D block fills and D-side
// write-through stores, sequencing fill addresses and steering read returns.
module mem_arbiter #(
   parameter  int BLOCK_WORDS = 8,
   localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_miss,
   input  logic [15:0]      i_miss_addr,
   input  logic             d_miss,
   input  logic [15:0]      d_miss_addr,
   input  logic             d_wr,
   input  logic [15:0]      d_wr_addr,
   input  logic [15:0]      d_wr_data,
   output logic             mem_en,
   output logic             mem_wr,
   output logic [15:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_rvalid,
   output logic [15:0]      fill_data,
   output logic [IDX_W-1:0] fill_word,
   output logic             fill_i_we,
   output logic             fill_d_we,
   output logic             i_done,
   output logic             d_done,
   output logic             d_wr_ack,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

   localparam logic [15:0]      BASE_MASK = ~16'(2 * BLOCK_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

   state_t             state_q, state_d;
   logic               owner_q, owner_d;   // 1 = D-cache owns the fill
   logic [15:0]        addr_q,  addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic [IDX_W:0]     k_q,     k_d;       // MSB set once every word is issued
   logic [IDX_W-1:0]   r_q,     r_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         k_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         k_q     <= k_d;
         r_q     <= r_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      k_d       = k_q;
      r_d       = r_q;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_data = '0;
      fill_word = '0;
      fill_i_we = 1'b0;
      fill_d_we = 1'b0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      d_wr_ack  = 1'b0;
      busy      = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            k_d = '0;
            r_d = '0;
            if (d_wr) begin
               state_d = WRITE;
               addr_d  = d_wr_addr;
               wdata_d = d_wr_data;
            end else if (d_miss) begin
               state_d = FILL;
               owner_d = 1'b1;
               addr_d  = d_miss_addr & BASE_MASK;
            end else if (i_miss) begin
               state_d = FILL;
               owner_d = 1'b0;
               addr_d  = i_miss_addr & BASE_MASK;
            end
         end

         WRITE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            d_wr_ack  = 1'b1;
            state_d   = IDLE;
         end

         FILL: begin
            if (!k_q[IDX_W]) begin
               mem_en   = 1'b1;
               mem_addr = addr_q + 16'({k_q[IDX_W-1:0], 1'b0});
               k_d      = k_q + 1'b1;
            end
            // Returns arrive in issue order, so r_q alone names the word.
            if (mem_rvalid) begin
               fill_data = mem_rdata;
               fill_word = r_q;
               fill_i_we = !owner_q;
               fill_d_we = owner_q;
               r_d       = r_q + 1'b1;
               if (r_q == LAST_WORD) begin
                  i_done  = !owner_q;
                  d_done  = owner_q;
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a fixed-latency memory model whose
// read data is the word address XOR 0x5A5A.
module tb_mem_arbiter;
   localparam int BW = 8;
   localparam int L  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_miss = 1'b0, d_miss = 1'b0, d_wr = 1'b0;
   logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
   logic        mem_en, mem_wr, mem_rvalid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
   logic [2:0]  fill_word;
   logic        fill_i_we, fill_d_we, i_done, d_done, d_wr_ack, busy;

   logic        frc_rv = 1'b0;
   logic [15:0] frc_data = '0;
   logic [L-1:0] pv = '0;
   logic [15:0]  pa [L] = '{default: '0};

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Memory model: not reset, so returns already in flight keep coming.
   always @(posedge clk) begin
      pv    <= {pv[L-2:0], mem_en & ~mem_wr};
      pa[0] <= mem_addr;
      for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
   end
   assign mem_rvalid = pv[L-1] | frc_rv;
   assign mem_rdata  = frc_rv ? frc_data : (pa[L-1] ^ 16'h5A5A);

   mem_arbiter #(.BLOCK_WORDS(BW)) dut (
      .clk(clk), .rst(rst),
      .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr),
      .d_wr(d_wr), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .fill_data(fill_data), .fill_word(fill_word),
      .fill_i_we(fill_i_we), .fill_d_we(fill_d_we),
      .i_done(i_done), .d_done(d_done), .d_wr_ack(d_wr_ack), .busy(busy)
   );

   // Expected {mem_en, mem_wr, mem_addr} for a fill whose first issue is cycle s.
   function automatic logic [17:0] exp_iss(int c, int s, logic [15:0] base);
      if (c >= s && c < s + BW) return {2'b10, 16'(base + 16'(2 * (c - s)))};
      return '0;
   endfunction

   // Expected {i_we, d_we, i_done, d_done, word, data}; word w returns at s+w+L.
   function automatic logic [22:0] exp_fil(int c, int s, logic [15:0] base, bit is_d);
      int w;
      w = c - s - L;
      if (w >= 0 && w < BW)
         return {!is_d, is_d, (!is_d && w == BW-1), (is_d && w == BW-1), 3'(w),
                 16'(base + 16'(2 * w)) ^ 16'h5A5A};
      return '0;
   endfunction

   function automatic logic [17:0] obs_iss();
      return {mem_en, mem_wr, mem_addr};
   endfunction

   function automatic logic [22:0] obs_fil();
      if (fill_i_we | fill_d_we)
         return {fill_i_we, fill_d_we, i_done, d_done, fill_word, fill_data};
      return {fill_i_we, fill_d_we, i_done, d_done, 3'b0, 16'b0};
   endfunction

   function automatic logic [58:0] obs_all();
      return {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
              fill_i_we, fill_d_we, i_done, d_done, d_wr_ack, busy};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs_all() !== '0) begin
         n_fail++; $display("FAIL reset_outputs got %h exp 0", obs_all());
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs_all() !== '0) begin
         n_fail++; $display("FAIL idle_after_reset got %h exp 0", obs_all());
      end
   endtask

   task automatic test_i_fill();
      i_miss = 1'b1; i_miss_addr = 16'h1236;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_iss() !== exp_iss(c, 1, 16'h1230)) begin
            n_fail++; $display("FAIL i_fill_issue c=%0d got %h exp %h", c, obs_iss(), exp_iss(c, 1, 16'h1230));
         end
         n_cmp++;
         if (obs_fil() !== exp_fil(c, 1, 16'h1230, 1'b0)) begin
            n_fail++; $display("FAIL i_fill_ret c=%0d got %h exp %h", c, obs_fil(), exp_fil(c, 1, 16'h1230, 1'b0));
         end
         if (c == 12) i_miss = 1'b0;
      end
   endtask

   task automatic test_priority();
      d_miss = 1'b1; d_miss_addr = 16'h0040;
      i_miss = 1'b1; i_miss_addr = 16'h2000;
      for (int c = 1; c <= 27; c++) begin
         logic [17:0] ei;
         logic [22:0] ef;
         @(negedge clk);
         ei = exp_iss(c, 1, 16'h0040) | exp_iss(c, 14, 16'h2000);
         ef = exp_fil(c, 1, 16'h0040, 1'b1) | exp_fil(c, 14, 16'h2000, 1'b0);
         n_cmp++;
         if (obs_iss() !== ei) begin
            n_fail++; $display("FAIL prio_issue c=%0d got %h exp %h", c, obs_iss(), ei);
         end
         n_cmp++;
         if (obs_fil() !== ef) begin
            n_fail++; $display("FAIL prio_ret c=%0d got %h exp %h", c, obs_fil(), ef);
         end
         n_cmp++;
         if (busy !== (c != 13 && c <= 25)) begin
            n_fail++; $display("FAIL prio_busy c=%0d got %b exp %b", c, busy, (c != 13 && c <= 25));
         end
         if (c == 12) d_miss = 1'b0;
         if (c == 25) i_miss = 1'b0;
      end
   endtask

   task automatic test_write_then_fill();
      d_wr = 1'b1; d_wr_addr = 16'h00A4; d_wr_data = 16'hBEEF;
      d_miss = 1'b1; d_miss_addr = 16'h0084;
      for (int c = 1; c <= 16; c++) begin
         logic [17:0] ei;
         @(negedge clk);
         ei = (c == 1) ? {2'b11, 16'h00A4} : exp_iss(c, 3, 16'h0080);
         n_cmp++;
         if (obs_iss() !== ei) begin
            n_fail++; $display("FAIL wr_issue c=%0d got %h exp %h", c, obs_iss(), ei);
         end
         n_cmp++;
         if (d_wr_ack !== (c == 1)) begin
            n_fail++; $display("FAIL wr_ack c=%0d got %b exp %b", c, d_wr_ack, (c == 1));
         end
         if (c <= 2) begin
            n_cmp++;
            if (mem_wdata !== ((c == 1) ? 16'hBEEF : 16'h0000)) begin
               n_fail++; $display("FAIL wr_wdata c=%0d got %h", c, mem_wdata);
            end
         end
         n_cmp++;
         if (obs_fil() !== exp_fil(c, 3, 16'h0080, 1'b1)) begin
            n_fail++; $display("FAIL wr_dfill c=%0d got %h exp %h", c, obs_fil(), exp_fil(c, 3, 16'h0080, 1'b1));
         end
         if (c == 1) d_wr = 1'b0;
         if (c == 14) d_miss = 1'b0;
      end
   endtask

   task automatic test_wrap();
      i_miss = 1'b1; i_miss_addr = 16'hFFF2;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_iss() !== exp_iss(c, 1, 16'hFFF0)) begin
            n_fail++; $display("FAIL wrap_issue c=%0d got %h exp %h", c, obs_iss(), exp_iss(c, 1, 16'hFFF0));
         end
         n_cmp++;
         if (obs_fil() !== exp_fil(c, 1, 16'hFFF0, 1'b0)) begin
            n_fail++; $display("FAIL wrap_ret c=%0d got %h exp %h", c, obs_fil(), exp_fil(c, 1, 16'hFFF0, 1'b0));
         end
         if (c == 12) i_miss = 1'b0;
      end
   endtask

   task automatic test_stray();
      @(negedge clk);
      frc_rv = 1'b1; frc_data = 16'h1234;
      #1;
      n_cmp++;
      if ({fill_i_we, fill_d_we, i_done, d_done, busy} !== 5'b0) begin
         n_fail++; $display("FAIL stray_we got %b exp 00000", {fill_i_we, fill_d_we, i_done, d_done, busy});
      end
      @(negedge clk);
      frc_rv = 1'b0;
      n_cmp++;
      if ({busy, mem_en} !== 2'b00) begin
         n_fail++; $display("FAIL stray_state got %b exp 00", {busy, mem_en});
      end
   endtask

   task automatic test_reset_midfill();
      i_miss = 1'b1; i_miss_addr = 16'h0100;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_fil() !== exp_fil(c, 1, 16'h0100, 1'b0)) begin
            n_fail++; $display("FAIL rstmid_pre c=%0d got %h exp %h", c, obs_fil(), exp_fil(c, 1, 16'h0100, 1'b0));
         end
      end
      rst = 1'b1; i_miss = 1'b0;
      #1;
      n_cmp++;
      if (obs_all() !== '0) begin
         n_fail++; $display("FAIL rstmid_outputs got %h exp 0", obs_all());
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({fill_i_we, fill_d_we, i_done, d_done, busy, mem_en} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_drain c=%0d got %b exp 000000", c,
                               {fill_i_we, fill_d_we, i_done, d_done, busy, mem_en});
         end
      end
      i_miss = 1'b1; i_miss_addr = 16'h0300;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         n_cmp++;
         if (obs_iss() !== exp_iss(c, 1, 16'h0300)) begin
            n_fail++; $display("FAIL rstmid_issue c=%0d got %h exp %h", c, obs_iss(), exp_iss(c, 1, 16'h0300));
         end
         n_cmp++;
         if (obs_fil() !== exp_fil(c, 1, 16'h0300, 1'b0)) begin
            n_fail++; $display("FAIL rstmid_refill c=%0d got %h exp %h", c, obs_fil(), exp_fil(c, 1, 16'h0300, 1'b0));
         end
         if (c == 12) i_miss = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_i_fill();
      test_priority();
      test_write_then_fill();
      test_wrap();
      test_stray();
      test_reset_midfill();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single pipelined main-memory port between the instruction-cache miss handler, the data-cache miss handler and data-side write-through stores.
- On a cache miss it sequences a full block fill: it issues one word address per cycle, then steers the returning words into the requesting cache's fill port.
- Sits between the I/D caches and main memory, beneath the fetch and memory stages of the 16-bit pipeline.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block. Must be a power of two, at least 2. IDX_W = log2(BLOCK_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_miss  in  1  I-cache fill request, level; held until i_done.
- i_miss_addr  in  16  byte address of the I-side miss.
- d_miss  in  1  D-cache fill request, level; held until d_done.
- d_miss_addr  in  16  byte address of the D-side miss.
- d_wr  in  1  write-through store request, level; held until d_wr_ack.
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory request valid this cycle.
- mem_wr  out  1  1 = write, 0 = read; qualified by mem_en.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  read data from memory.
- mem_rvalid  in  1  mem_rdata valid; arrives a fixed latency after each read, in issue order.
- fill_data  out  16  word being filled; equals mem_rdata.
- fill_word  out  IDX_W  word index within the block.
- fill_i_we  out  1  I-cache fill write enable.
- fill_d_we  out  1  D-cache fill write enable.
- i_done  out  1  one-cycle pulse: I fill complete.
- d_done  out  1  one-cycle pulse: D fill complete.
- d_wr_ack  out  1  one-cycle pulse: store issued to memory.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched owner, address and data cleared. Reset asserted mid-transaction abandons it: no done or ack pulse is produced, and outstanding mem_rvalid returns are ignored after reset.
- States: IDLE, WRITE, FILL.
- Arbitration in IDLE uses fixed priority d_wr > d_miss > i_miss, evaluated on the current cycle's inputs. The grant is registered and the next state is entered on the following edge.
  - d_wr grant: latch d_wr_addr and d_wr_data, go to WRITE.
  - Miss grant: latch owner (I or D) and base = miss_addr & ~(2*BLOCK_WORDS-1), go to FILL.
- WRITE (exactly one cycle):
  - mem_en=1, mem_wr=1, mem_addr and mem_wdata = latched values, d_wr_ack=1.
  - Next state IDLE. The requester deasserts d_wr after it sees ack.
- FILL:
  - Issue counter k runs 0..BLOCK_WORDS-1. While k < BLOCK_WORDS: mem_en=1, mem_wr=0, mem_addr = base + 2*k (16-bit wrap), k increments.
  - Receive counter r: on each mem_rvalid, fill_data = mem_rdata, fill_word = r, and the owner's fill_*_we = 1 (combinational, same cycle); r then increments.
  - On the rvalid where r = BLOCK_WORDS-1, the owner's done pulses in that same cycle and the next state is IDLE.
  - A new grant is possible in the IDLE cycle that follows.
- mem_rvalid outside FILL: ignored; no write enables asserted.
- Requests arriving during WRITE or FILL wait. A lower-priority request is never starved by a single higher-priority transaction, because arbitration re-occurs in IDLE.
- A requester dropping its miss mid-fill does not abort the transaction; the fill and done still complete.
- mem_addr and mem_wdata are 0 whenever mem_en=0.
- busy=1 in WRITE and FILL.
- Fill latency with memory latency L: first mem_en at grant+1, done at grant + BLOCK_WORDS + L.

Test Plan:
- Reset mid-fill: assert rst while in FILL -> all outputs 0 immediately; subsequent rvalids produce no fill_*_we; the next i_miss fills normally.
- Single I fill (mem latency 4): i_miss, i_miss_addr=0x1236 -> mem_en for 8 cycles with mem_addr 0x1230, 0x1232, …, 0x123E; 8 fill_i_we pulses with fill_word 0..7; i_done on the 8th pulse, 12 cycles after grant; fill_d_we stays 0.
- Simultaneous d_miss=0x0040, i_miss=0x2000 -> D block 0x0040..0x004E fills first with d_done; then the I fill of 0x2000 starts the cycle after IDLE.
- d_wr (addr 0x00A4, data 0xBEEF) together with d_miss -> one-cycle write (mem_wr=1, mem_addr=0x00A4, mem_wdata=0xBEEF, d_wr_ack=1) precedes the D fill.
- Address wrap: i_miss_addr=0xFFF2 -> base 0xFFF0, addresses 0xFFF0..0xFFFE, no overflow.
- Stray mem_rvalid while IDLE with mem_rdata=0x1234 -> fill_i_we=fill_d_we=0, state unchanged.
